// File: rtl/poly_mult_run_ctrl.sv
// Run sequencer for a multi-cycle poly_mult core: repeats the operation a set
// number of times with optional LFSR-selected dummy runs, a timeout and a scope trigger.
module poly_mult_run_ctrl #(
    parameter int pDATA_WIDTH  = 128,
    parameter int pKEY_WIDTH   = 256,
    parameter int pCNT_WIDTH   = 8,
    parameter int pTIMEOUT_CYC = 4096,
    parameter int pTRIG_ALL    = 0,
    parameter int pMAX_DUMMY   = 3
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [pKEY_WIDTH-1:0]  key_i,
    input  logic [pDATA_WIDTH-1:0] text_i,
    input  logic [pCNT_WIDTH-1:0]  repeat_i,
    input  logic                   dummy_en_i,
    input  logic [15:0]            seed_i,
    input  logic                   seed_load_i,
    output logic                   core_load_o,
    output logic [pKEY_WIDTH-1:0]  core_key_o,
    output logic [pDATA_WIDTH-1:0] core_data_o,
    input  logic [pDATA_WIDTH-1:0] core_data_i,
    input  logic                   core_busy_i,
    output logic [pDATA_WIDTH-1:0] result_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   trigger_o,
    output logic                   timeout_o,
    output logic [pCNT_WIDTH-1:0]  run_cnt_o,
    output logic [pCNT_WIDTH-1:0]  dummy_cnt_o
);

    localparam int TMO_W = (pTIMEOUT_CYC < 2) ? 1 : $clog2(pTIMEOUT_CYC);
    localparam int KREP  = (pKEY_WIDTH + 15) / 16;
    localparam int DREP  = (pDATA_WIDTH + 15) / 16;
    localparam logic [TMO_W-1:0]      TMO_LIM = TMO_W'(pTIMEOUT_CYC - 1);
    localparam logic [pCNT_WIDTH-1:0] CMAX    = pCNT_WIDTH'(pMAX_DUMMY);

    typedef enum logic [2:0] {IDLE, DECIDE, LOAD, WAIT, RUN, DONE} state_t;

    state_t                 state;
    logic [pKEY_WIDTH-1:0]  key_q;
    logic [pDATA_WIDTH-1:0] text_q;
    logic [pCNT_WIDTH-1:0]  rep_q;
    logic [pCNT_WIDTH-1:0]  consec;
    logic                   dummy_q;
    logic [15:0]            lfsr;
    logic [TMO_W-1:0]       tmo_cnt;

    logic [15:0]            lfsr_next;
    logic [KREP*16-1:0]     key_rep;
    logic [DREP*16-1:0]     data_rep;
    logic [pCNT_WIDTH-1:0]  consec_after;
    logic [pCNT_WIDTH-1:0]  run_next;
    logic                   dec_dummy;
    logic                   ahead_dummy;

    function automatic logic pick_dummy(input logic en, input logic [15:0] l,
                                        input logic [pCNT_WIDTH-1:0] c);
        return en && l[0] && (c < CMAX);
    endfunction

    function automatic logic qualifies(input logic d);
        return (pTRIG_ALL != 0) || !d;
    endfunction

    always_comb begin
        lfsr_next    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        key_rep      = {KREP{lfsr_next}};
        data_rep     = {DREP{lfsr_next}};
        dec_dummy    = pick_dummy(dummy_en_i, lfsr_next, consec);
        consec_after = dummy_q ? consec + 1'b1 : consec;
        // Predicts the next DECIDE outcome so the trigger can stay high across DECIDE.
        ahead_dummy  = pick_dummy(dummy_en_i, lfsr_next, consec_after);
        run_next     = run_cnt_o + 1'b1;
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= IDLE;
            key_q       <= '0;
            text_q      <= '0;
            rep_q       <= '0;
            consec      <= '0;
            dummy_q     <= 1'b0;
            lfsr        <= 16'hACE1;
            tmo_cnt     <= '0;
            core_load_o <= 1'b0;
            core_key_o  <= '0;
            core_data_o <= '0;
            result_o    <= '0;
            done_o      <= 1'b0;
            trigger_o   <= 1'b0;
            timeout_o   <= 1'b0;
            run_cnt_o   <= '0;
            dummy_cnt_o <= '0;
        end else begin
            core_load_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load_i) lfsr <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
                    if (start_i) begin
                        key_q       <= key_i;
                        text_q      <= text_i;
                        rep_q       <= (repeat_i == '0) ? pCNT_WIDTH'(1) : repeat_i;
                        run_cnt_o   <= '0;
                        dummy_cnt_o <= '0;
                        consec      <= '0;
                        timeout_o   <= 1'b0;
                        done_o      <= 1'b0;
                        state       <= DECIDE;
                    end
                end
                DECIDE: begin
                    lfsr        <= lfsr_next;
                    dummy_q     <= dec_dummy;
                    if (!dec_dummy) consec <= '0;
                    core_load_o <= 1'b1;
                    core_key_o  <= dec_dummy ? key_rep[pKEY_WIDTH-1:0] : key_q;
                    core_data_o <= dec_dummy ? data_rep[pDATA_WIDTH-1:0] : text_q;
                    trigger_o   <= qualifies(dec_dummy);
                    state       <= LOAD;
                end
                LOAD: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT, RUN: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (state == RUN && !core_busy_i) begin
                        if (dummy_q) begin
                            if (dummy_cnt_o != '1) dummy_cnt_o <= dummy_cnt_o + 1'b1;
                            consec    <= consec_after;
                            trigger_o <= qualifies(1'b1) && qualifies(ahead_dummy);
                            state     <= DECIDE;
                        end else begin
                            result_o  <= core_data_i;
                            run_cnt_o <= run_next;
                            if (run_next == rep_q) begin
                                trigger_o <= 1'b0;
                                done_o    <= 1'b1;
                                state     <= DONE;
                            end else begin
                                trigger_o <= qualifies(1'b0) && qualifies(ahead_dummy);
                                state     <= DECIDE;
                            end
                        end
                    end else if (tmo_cnt == TMO_LIM) begin
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        trigger_o <= 1'b0;
                        state     <= DONE;
                    end else if (state == WAIT && core_busy_i) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
